// File: rtl/tx_link_arbiter_if.sv
// tx_link_arbiter_if: requester and transmitter handshake bundle.
// master = arbiter side, slave = requesters + tx block side.
interface tx_link_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    Req_Valid;
    logic [32*NUM_REQ-1:0] Req_Data;
    logic [NUM_REQ-1:0]    Req_Ack;
    logic [NUM_REQ-1:0]    Req_Done;
    logic [NUM_REQ-1:0]    Req_Drop;
    logic                  TxData_Valid;
    logic [31:0]           TxData;
    logic                  Error_Ack;
    logic                  Tx_Ready;
    logic                  Tx_Error;
    logic [IDW-1:0]        Grant_Id;
    logic                  Busy;

    modport master (
        input  Req_Valid, Req_Data, Tx_Ready, Tx_Error,
        output Req_Ack, Req_Done, Req_Drop,
        output TxData_Valid, TxData, Error_Ack,
        output Grant_Id, Busy
    );

    modport slave (
        output Req_Valid, Req_Data, Tx_Ready, Tx_Error,
        input  Req_Ack, Req_Done, Req_Drop,
        input  TxData_Valid, TxData, Error_Ack,
        input  Grant_Id, Busy
    );
endinterface

// File: rtl/tx_link_arbiter.sv
// tx_link_arbiter: round-robin share of one serial tx among NUM_REQ
// requesters, with a post-send error window and bounded retransmission.
// Ports: Clk_s, Rst_n (async, active-low); bus (master modport):
//   Req_Valid/Req_Data in, Req_Ack/Req_Done/Req_Drop pulses out,
//   TxData_Valid/TxData/Error_Ack out, Tx_Ready/Tx_Error in,
//   Grant_Id/Busy status out. All outputs registered.
module tx_link_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_RETRY = 2,
    parameter int ERR_WAIT  = 8
) (
    input  logic Clk_s,
    input  logic Rst_n,
    tx_link_arbiter_if.master bus
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int RW  = $clog2(MAX_RETRY + 2);
    localparam int CW  = (ERR_WAIT > 1) ? $clog2(ERR_WAIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_XMIT, S_CHECK, S_ERRACK
    } state_t;

    state_t             r_state;
    logic [IDW-1:0]     r_ptr;
    logic [IDW-1:0]     r_gnt;
    logic [31:0]        r_buf;
    logic               r_valid;
    logic               r_eack;
    logic               r_busy;
    logic               r_stale;
    logic [RW-1:0]      r_retry;
    logic [CW-1:0]      r_cnt;
    logic [NUM_REQ-1:0] r_ack;
    logic [NUM_REQ-1:0] r_done;
    logic [NUM_REQ-1:0] r_drop;

    logic               w_any;
    logic [IDW-1:0]     w_gid;

    // Scan downward so the last hit is the nearest one above r_ptr.
    always_comb begin
        w_any = 1'b0;
        w_gid = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            int idx;
            idx = int'(r_ptr) + k;
            if (idx >= NUM_REQ)
                idx = idx - NUM_REQ;
            if (bus.Req_Valid[IDW'(idx)]) begin
                w_any = 1'b1;
                w_gid = IDW'(idx);
            end
        end
    end

    always_ff @(posedge Clk_s or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= IDW'(NUM_REQ - 1);
            r_gnt   <= '0;
            r_buf   <= '0;
            r_valid <= 1'b0;
            r_eack  <= 1'b0;
            r_busy  <= 1'b0;
            r_stale <= 1'b0;
            r_retry <= '0;
            r_cnt   <= '0;
            r_ack   <= '0;
            r_done  <= '0;
            r_drop  <= '0;
        end else begin
            r_ack  <= '0;
            r_done <= '0;
            r_drop <= '0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt        <= w_gid;
                        r_buf        <= bus.Req_Data[32*int'(w_gid) +: 32];
                        r_ack[w_gid] <= 1'b1;
                        r_retry      <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (r_valid) begin
                        if (!bus.Tx_Ready) begin
                            r_valid <= 1'b0;
                            r_state <= S_XMIT;
                        end
                    end else if (bus.Tx_Error) begin
                        // Leftover error from before this send: clear it,
                        // but it is not charged against the retry budget.
                        r_eack  <= 1'b1;
                        r_stale <= 1'b1;
                        r_state <= S_ERRACK;
                    end else if (bus.Tx_Ready) begin
                        r_valid <= 1'b1;
                    end
                end
                S_XMIT: begin
                    if (bus.Tx_Ready) begin
                        r_cnt   <= CW'(ERR_WAIT - 1);
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (bus.Tx_Error) begin
                        r_eack  <= 1'b1;
                        r_stale <= 1'b0;
                        r_state <= S_ERRACK;
                    end else if (r_cnt == '0) begin
                        r_done[r_gnt] <= 1'b1;
                        r_ptr         <= r_gnt;
                        r_busy        <= 1'b0;
                        r_state       <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_ERRACK: begin
                    if (!bus.Tx_Error) begin
                        r_eack <= 1'b0;
                        if (r_stale) begin
                            r_state <= S_SEND;
                        end else if (r_retry < RW'(MAX_RETRY)) begin
                            r_retry <= r_retry + RW'(1);
                            r_state <= S_SEND;
                        end else begin
                            r_drop[r_gnt] <= 1'b1;
                            r_ptr         <= r_gnt;
                            r_busy        <= 1'b0;
                            r_state       <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.Req_Ack      = r_ack;
    assign bus.Req_Done     = r_done;
    assign bus.Req_Drop     = r_drop;
    assign bus.TxData_Valid = r_valid;
    assign bus.TxData       = r_buf;
    assign bus.Error_Ack    = r_eack;
    assign bus.Grant_Id     = r_gnt;
    assign bus.Busy         = r_busy;
endmodule
